// File: rtl/apb_arb_master_if.sv
// APB bus bundle between the arbitrating master and the shared slave.
// The master modport drives the request phase; the slave modport answers.
interface apb_arb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_arb_master.sv
// Round-robin arbitrated APB master: shares one APB bus among NUM_REQ local
// requesters, sequences SETUP/ACCESS, and aborts transfers on pready timeout.
module apb_arb_master #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        timeout_evt,
    apb_arb_master_if.master            apb
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [GW-1:0]       last, last_n;
    logic [GW-1:0]       grant_n;
    logic [CW-1:0]       cnt, cnt_n;

    logic                psel_q, psel_n;
    logic                penable_q, penable_n;
    logic                pwrite_q, pwrite_n;
    logic [ADDR_W-1:0]   paddr_q, paddr_n;
    logic [DATA_W-1:0]   pwdata_q, pwdata_n;

    logic [NUM_REQ-1:0]  req_done_n;
    logic [DATA_W-1:0]   rsp_rdata_n;
    logic                rsp_err_n;
    logic                busy_n;
    logic                timeout_n;

    logic                win_found;
    logic [GW-1:0]       win_idx;
    logic [GW-1:0]       cand;
    int                  idx;

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;

    // Search starts just after the last winner, so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last;
        cand      = last;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(last) + k) % NUM_REQ;
            cand = GW'(idx);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_n     = state;
        last_n      = last;
        grant_n     = grant_id;
        cnt_n       = cnt;
        psel_n      = psel_q;
        penable_n   = penable_q;
        pwrite_n    = pwrite_q;
        paddr_n     = paddr_q;
        pwdata_n    = pwdata_q;
        req_done_n  = '0;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        timeout_n   = 1'b0;

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n   = SETUP;
                    grant_n   = win_idx;
                    last_n    = win_idx;
                    pwrite_n  = req_write[win_idx];
                    paddr_n   = req_addr[win_idx*ADDR_W +: ADDR_W];
                    pwdata_n  = req_wdata[win_idx*DATA_W +: DATA_W];
                    psel_n    = 1'b1;
                    penable_n = 1'b0;
                end
            end
            SETUP: begin
                state_n   = ACCESS;
                psel_n    = 1'b1;
                penable_n = 1'b1;
            end
            ACCESS: begin
                // A late pready on the final allowed cycle still completes normally.
                if (apb.pready) begin
                    state_n     = DONE;
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    rsp_rdata_n = pwrite_q ? '0 : apb.prdata;
                    rsp_err_n   = apb.pslverr;
                    req_done_n  = NUM_REQ'(1) << grant_id;
                end else begin
                    cnt_n = cnt + CW'(1);
                    if (cnt_n == CW'(TIMEOUT_CYC)) begin
                        state_n     = DONE;
                        psel_n      = 1'b0;
                        penable_n   = 1'b0;
                        rsp_rdata_n = '0;
                        rsp_err_n   = 1'b1;
                        timeout_n   = 1'b1;
                        req_done_n  = NUM_REQ'(1) << grant_id;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n   = IDLE;
                psel_n    = 1'b0;
                penable_n = 1'b0;
                cnt_n     = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            last        <= GW'(NUM_REQ - 1);
            grant_id    <= '0;
            cnt         <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            req_done    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_n;
            last        <= last_n;
            grant_id    <= grant_n;
            cnt         <= cnt_n;
            psel_q      <= psel_n;
            penable_q   <= penable_n;
            pwrite_q    <= pwrite_n;
            paddr_q     <= paddr_n;
            pwdata_q    <= pwdata_n;
            req_done    <= req_done_n;
            rsp_rdata   <= rsp_rdata_n;
            rsp_err     <= rsp_err_n;
            busy        <= busy_n;
            timeout_evt <= timeout_n;
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: a per-cycle vector table for the basic
// transfers plus hand-written timeout, mid-transfer reset and round-robin runs.
module tb_apb_arb_master;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              pclk = 1'b0;
    logic              preset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic [1:0]        grant_id;
    logic              timeout_evt;

    apb_arb_master_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

    apb_arb_master #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .grant_id(grant_id), .timeout_evt(timeout_evt),
        .apb(apb)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  write;
        logic        pready;
        logic        pslverr;
        logic [31:0] prdata;
        logic        e_psel;
        logic        e_pen;
        logic [3:0]  e_done;
        logic        e_busy;
        logic        e_err;
        logic        e_tmo;
        logic [31:0] e_rdata;
        logic [1:0]  e_gid;
        logic [31:0] e_paddr;
        logic        e_pwrite;
        logic [31:0] e_pwdata;
    } vec_t;

    vec_t tbl [16];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] v, input logic [3:0] w,
                                  input logic rdy, input logic err, input logic [31:0] rd);
        req_valid   = v;
        req_write   = w;
        apb.pready  = rdy;
        apb.pslverr = err;
        apb.prdata  = rd;
    endtask

    task automatic apply_reset(input string tag);
        preset = 1'b1;
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge pclk);
        check_output({tag, "_psel"},     32'(apb.psel), 32'h0);
        check_output({tag, "_penable"},  32'(apb.penable), 32'h0);
        check_output({tag, "_paddr"},    apb.paddr, 32'h0);
        check_output({tag, "_pwdata"},   apb.pwdata, 32'h0);
        check_output({tag, "_done"},     32'(req_done), 32'h0);
        check_output({tag, "_busy"},     32'(busy), 32'h0);
        check_output({tag, "_rdata"},    rsp_rdata, 32'h0);
        check_output({tag, "_err"},      32'(rsp_err), 32'h0);
        check_output({tag, "_gid"},      32'(grant_id), 32'h0);
        check_output({tag, "_tmo"},      32'(timeout_evt), 32'h0);
        preset = 1'b0;
    endtask

    initial begin
        bit   got_done;
        int   acc_cycles;
        int   rr_exp [5];

        req_addr  = {32'h0000_A00C, 32'h0000_A000, 32'h0000_A004, 32'h0000_A000};
        req_wdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF};

        //        valid    write    rdy  serr prdata        psel pen done     busy err  tmo  rdata         gid    paddr         pwr  pwdata
        tbl[0]  = '{4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 32'h0,      1'b0, 32'h0};
        tbl[1]  = '{4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0, 32'hA000,   1'b1, 32'hDEADBEEF};
        tbl[2]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0, 32'hA000,   1'b1, 32'hDEADBEEF};
        tbl[3]  = '{4'b0001, 4'b0001, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h0,        2'd0, 32'hA000,   1'b1, 32'hDEADBEEF};
        tbl[4]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 32'hA000,   1'b1, 32'hDEADBEEF};
        tbl[5]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0,        2'd2, 32'hA000,   1'b0, 32'h33333333};
        tbl[6]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0,        2'd2, 32'hA000,   1'b0, 32'h33333333};
        tbl[7]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0,        2'd2, 32'hA000,   1'b0, 32'h33333333};
        tbl[8]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0,        2'd2, 32'hA000,   1'b0, 32'h33333333};
        tbl[9]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 32'h12345678, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0,        2'd2, 32'hA000,   1'b0, 32'h33333333};
        tbl[10] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 32'h12345678, 2'd2, 32'hA000,   1'b0, 32'h33333333};
        tbl[11] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h12345678, 2'd2, 32'hA000,   1'b0, 32'h33333333};
        tbl[12] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h12345678, 2'd1, 32'hA004,   1'b1, 32'h22222222};
        tbl[13] = '{4'b0010, 4'b0010, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h12345678, 2'd1, 32'hA004,   1'b1, 32'h22222222};
        tbl[14] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 32'h0,        2'd1, 32'hA004,   1'b1, 32'h22222222};
        tbl[15] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 32'h0,        2'd1, 32'hA004,   1'b1, 32'h22222222};

        apply_reset("rst0");

        for (int i = 0; i < 16; i++) begin
            @(negedge pclk);
            check_output($sformatf("row%0d_psel", i),    32'(apb.psel),    32'(tbl[i].e_psel));
            check_output($sformatf("row%0d_penable", i), 32'(apb.penable), 32'(tbl[i].e_pen));
            check_output($sformatf("row%0d_done", i),    32'(req_done),    32'(tbl[i].e_done));
            check_output($sformatf("row%0d_busy", i),    32'(busy),        32'(tbl[i].e_busy));
            check_output($sformatf("row%0d_err", i),     32'(rsp_err),     32'(tbl[i].e_err));
            check_output($sformatf("row%0d_tmo", i),     32'(timeout_evt), 32'(tbl[i].e_tmo));
            check_output($sformatf("row%0d_rdata", i),   rsp_rdata,        tbl[i].e_rdata);
            check_output($sformatf("row%0d_gid", i),     32'(grant_id),    32'(tbl[i].e_gid));
            check_output($sformatf("row%0d_paddr", i),   apb.paddr,        tbl[i].e_paddr);
            check_output($sformatf("row%0d_pwrite", i),  32'(apb.pwrite),  32'(tbl[i].e_pwrite));
            check_output($sformatf("row%0d_pwdata", i),  apb.pwdata,       tbl[i].e_pwdata);
            apply_stimulus(tbl[i].valid, tbl[i].write, tbl[i].pready, tbl[i].pslverr, tbl[i].prdata);
        end

        $display("[TB] timeout sequence");
        apply_stimulus(4'b1000, 4'b0000, 1'b0, 1'b0, 32'hFFFF_FFFF);
        got_done   = 1'b0;
        acc_cycles = 0;
        for (int k = 0; k < 40 && !got_done; k++) begin
            @(negedge pclk);
            if (req_done != 4'b0000) got_done = 1'b1;
            else if (apb.psel && apb.penable) acc_cycles++;
        end
        check_output("tmo_done_seen",   32'(got_done),    32'h1);
        check_output("tmo_access_cnt",  32'(acc_cycles),  32'(TO));
        check_output("tmo_done",        32'(req_done),    32'h8);
        check_output("tmo_err",         32'(rsp_err),     32'h1);
        check_output("tmo_rdata",       rsp_rdata,        32'h0);
        check_output("tmo_evt",         32'(timeout_evt), 32'h1);
        check_output("tmo_gid",         32'(grant_id),    32'h3);
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        @(negedge pclk);
        check_output("tmo_idle_busy",   32'(busy),        32'h0);
        check_output("tmo_idle_psel",   32'(apb.psel),    32'h0);
        check_output("tmo_idle_evt",    32'(timeout_evt), 32'h0);
        check_output("tmo_idle_done",   32'(req_done),    32'h0);

        $display("[TB] reset during ACCESS sequence");
        apply_stimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 32'h0);
        @(negedge pclk);
        check_output("mrst_setup_psel", 32'(apb.psel),    32'h1);
        check_output("mrst_setup_gid",  32'(grant_id),    32'h1);
        @(negedge pclk);
        check_output("mrst_acc_pen",    32'(apb.penable), 32'h1);
        @(negedge pclk);
        check_output("mrst_acc2_pen",   32'(apb.penable), 32'h1);
        preset = 1'b1;
        @(negedge pclk);
        check_output("mrst_psel",       32'(apb.psel),    32'h0);
        check_output("mrst_penable",    32'(apb.penable), 32'h0);
        check_output("mrst_done",       32'(req_done),    32'h0);
        check_output("mrst_busy",       32'(busy),        32'h0);
        preset = 1'b0;
        apply_stimulus(4'b1001, 4'b0000, 1'b0, 1'b0, 32'h0);
        @(negedge pclk);
        check_output("mrst_regrant_gid",   32'(grant_id), 32'h0);
        check_output("mrst_regrant_psel",  32'(apb.psel), 32'h1);
        check_output("mrst_regrant_paddr", apb.paddr,     32'hA000);
        @(negedge pclk);
        apply_stimulus(4'b1001, 4'b0000, 1'b1, 1'b0, 32'hCAFE_F00D);
        @(negedge pclk);
        check_output("mrst_regrant_done",  32'(req_done), 32'h1);
        check_output("mrst_regrant_rdata", rsp_rdata,     32'hCAFE_F00D);
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);

        apply_reset("rst1");

        $display("[TB] round-robin sequence");
        rr_exp = '{0, 1, 2, 3, 0};
        apply_stimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 32'h0);
        for (int j = 0; j < 5; j++) begin
            got_done = 1'b0;
            for (int k = 0; k < 10 && !got_done; k++) begin
                @(negedge pclk);
                if (req_done != 4'b0000) got_done = 1'b1;
            end
            check_output($sformatf("rr%0d_seen", j), 32'(got_done), 32'h1);
            check_output($sformatf("rr%0d_done", j), 32'(req_done), 32'(4'b0001 << rr_exp[j]));
            check_output($sformatf("rr%0d_gid", j),  32'(grant_id), 32'(rr_exp[j]));
        end
        apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge pclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
- Multi-requester APB master that shares one APB bus (e.g. the slave at 0xA000) between NUM_REQ local requesters.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases.
- Captures read data and slave error, and aborts transfers whose slave never asserts pready.
- Sits between internal engines (DMA, config, test sequencer) and the APB interconnect.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYC, 16, maximum ACCESS cycles waiting for pready before abort (>=1)

Ports:
- pclk  input  1  APB clock; all logic on rising edge
- preset  input  1  synchronous reset, active-high
- req_valid  input  NUM_REQ  per-requester transfer request, held until its req_done
- req_write  input  NUM_REQ  per-requester direction (1 = write)
- req_addr  input  NUM_REQ*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  per-requester write data, same packing
- req_done  output  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester
- rsp_rdata  output  DATA_W  read data; valid while req_done is high
- rsp_err  output  1  error (pslverr or timeout); valid while req_done is high
- busy  output  1  high in SETUP, ACCESS and DONE
- grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester
- timeout_evt  output  1  one-cycle pulse in DONE when the transfer ended by timeout
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_W  APB address
- pwdata  output  DATA_W  APB write data
- prdata  input  DATA_W  APB read data
- pready  input  1  APB ready
- pslverr  input  1  APB slave error

Behaviour:
- All outputs are registered. On preset:
  - state = IDLE
  - psel, penable, pwrite = 0; paddr, pwdata = 0
  - req_done = 0; rsp_rdata = 0; rsp_err = 0; timeout_evt = 0; busy = 0
  - grant_id = 0; round-robin pointer last = NUM_REQ-1, so requester 0 wins first
  - timeout counter = 0
- Reset in any state, including mid-ACCESS, drops psel/penable in the next cycle. No req_done is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req_valid is high, pick the first set bit searching last+1, last+2, … with wrap modulo NUM_REQ.
  - Latch grant_id, pwrite, paddr and pwdata from the winner; update last = winner; go to SETUP.
  - With no request, stay in IDLE with psel = 0.
- SETUP (exactly 1 cycle): psel = 1, penable = 0; go to ACCESS.
- ACCESS: psel = 1, penable = 1; paddr, pwrite and pwdata stay stable.
  - If pready = 1: capture prdata into rsp_rdata when pwrite = 0, else rsp_rdata = 0. Capture rsp_err = pslverr. Go to DONE.
  - Otherwise increment the counter. If the counter reaches TIMEOUT_CYC without pready: rsp_rdata = 0, rsp_err = 1, set timeout_evt, go to DONE.
  - pready and timeout in the same cycle: pready wins, the transfer completes normally.
- DONE (exactly 1 cycle):
  - psel = 0, penable = 0.
  - req_done[grant_id] = 1; rsp_rdata and rsp_err hold their captured values.
  - Clear the counter and go to IDLE.
- Requester rule: drop req_valid on the edge that ends its req_done cycle. In the following IDLE cycle that requester does not compete unless it re-asserts.
- Latency: req_valid high in IDLE at cycle 0 gives SETUP at cycle 1 and ACCESS at cycle 2. With pready in cycle 2, DONE is cycle 3. Minimum 4 cycles per transfer, plus 1 cycle per wait state.
- A req_valid of a non-granted requester that changes during a transfer has no effect until the next IDLE.
- rsp_rdata and rsp_err hold their value after DONE until the next DONE.
- busy = 1 in SETUP, ACCESS and DONE.

Test Plan:
- Single write: req 0 writes 0xDEADBEEF to 0xA000, slave pready = 1 immediately. Required: psel=1/penable=0 in cycle 1, psel=1/penable=1 in cycle 2, req_done=4'b0001 in cycle 3, rsp_err=0.
- Read with 3 wait states: req 2 reads 0xA000, pready asserted on the 4th ACCESS cycle with prdata = 0x12345678. Required: req_done=4'b0100 in cycle 6, rsp_rdata=0x12345678, paddr stable throughout.
- Round-robin: all four requesters assert simultaneously and re-assert after each done. Required: grant order 0,1,2,3,0.
- Slave error: pslverr=1 together with pready on a req 1 write. Required: rsp_err=1, timeout_evt=0, req_done=4'b0010.
- Timeout: pready held low. Required: after 16 ACCESS cycles, DONE with rsp_err=1, rsp_rdata=0, timeout_evt=1; IDLE on the next cycle.
- Reset mid-ACCESS: assert preset during the 2nd wait cycle. Required: next cycle psel=0, penable=0, req_done=0, last=NUM_REQ-1; a subsequent request from req 3 with req 0 also asserted grants req 0 first.
